// File: rtl/uart_rx_birthday_match.sv
// rtl/uart_rx_birthday_match.sv - UART 8N1 receiver with "2000_10_29" string matcher
//
// Receives 8N1 frames on rx, presents each good byte with a one-cycle strobe,
// and watches the byte stream for the ASCII string "2000_10_29".
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   rx         asynchronous UART line, idles high
//   rx_data    last correctly framed byte
//   rx_valid   one-cycle strobe, rx_data valid this cycle
//   frame_err  one-cycle strobe, stop bit sampled low
//   match      one-cycle strobe, pattern just completed
//   led        toggles on every match
`timescale 1ns/1ps

module uart_rx_birthday_match #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       match,
    output logic       led
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state;
    logic               rx_meta;
    logic               rx_s;
    logic               rx_s_d;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;
    logic [3:0]         idx;

    function automatic logic [7:0] pattern_char(input logic [3:0] i);
        case (i)
            4'd0:    pattern_char = 8'h32;
            4'd1:    pattern_char = 8'h30;
            4'd2:    pattern_char = 8'h30;
            4'd3:    pattern_char = 8'h30;
            4'd4:    pattern_char = 8'h5F;
            4'd5:    pattern_char = 8'h31;
            4'd6:    pattern_char = 8'h30;
            4'd7:    pattern_char = 8'h5F;
            4'd8:    pattern_char = 8'h32;
            default: pattern_char = 8'h39;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_s_d    <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            match     <= 1'b0;
            led       <= 1'b0;
            idx       <= '0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            rx_s_d    <= rx_s;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            match     <= 1'b0;

            case (state)
                IDLE: begin
                    // Only a high-to-low transition starts a frame, so a held-low
                    // break line cannot retrigger until it returns high.
                    if (rx_s_d && !rx_s) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_FULL) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so a start bit right after it is caught.
                    if (cnt == CNT_FULL) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (rx_s) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Matcher consumes the registered byte, so match lands one cycle
            // after rx_valid.
            if (frame_err) begin
                idx <= '0;
            end else if (rx_valid) begin
                if (rx_data == pattern_char(idx)) begin
                    if (idx == 4'd9) begin
                        idx   <= '0;
                        match <= 1'b1;
                        led   <= ~led;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end else if (idx == 4'd9 && rx_data == 8'h30) begin
                    // "...2" followed by '0' is itself the prefix "20".
                    idx <= 4'd2;
                end else if (rx_data == 8'h32) begin
                    idx <= 4'd1;
                end else begin
                    idx <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_birthday_match.sv
// tb/tb_uart_rx_birthday_match.sv - scoreboard testbench for uart_rx_birthday_match
`timescale 1ns/1ps

module tb_uart_rx_birthday_match;

    localparam int CLK_FREQ = 4_608_000;
    localparam int BAUD     = 115200;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int LATENCY  = CPB * 9 + CPB / 2 + 3;

    localparam int EV_BYTE  = 0;
    localparam int EV_FERR  = 1;
    localparam int EV_MATCH = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       led;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       match;
    logic       led;

    ev_t        exp_q[$];
    int         n_checks;
    int         n_fail;
    int         cyc;
    int         t_start;
    logic       exp_led;

    uart_rx_birthday_match #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .match    (match),
        .led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check_event(input int kind);
        ev_t e;
        int  lat;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d data %02h, expected nothing", kind, rx_data);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind) begin
            n_fail++;
            $display("FAIL event_kind: got %0d, expected %0d", kind, e.kind);
        end else if (kind == EV_BYTE && rx_data !== e.data) begin
            n_fail++;
            $display("FAIL rx_data: got %02h, expected %02h", rx_data, e.data);
        end else if (kind == EV_MATCH && led !== e.led) begin
            n_fail++;
            $display("FAIL led_on_match: got %0b, expected %0b", led, e.led);
        end
        if (kind != EV_MATCH) begin
            lat = cyc - t_start;
            n_checks++;
            if (lat < LATENCY - 1 || lat > LATENCY + 1) begin
                n_fail++;
                $display("FAIL latency: got %0d clocks, expected %0d +/-1", lat, LATENCY);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && frame_err) begin
                n_checks++;
                n_fail++;
                $display("FAIL exclusive: rx_valid and frame_err both 1");
            end
            if (rx_valid)  check_event(EV_BYTE);
            if (frame_err) check_event(EV_FERR);
            if (match)     check_event(EV_MATCH);
        end
    end

    task automatic push(input int kind, input logic [7:0] data, input logic l);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.led  = l;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit exp_match);
        if (stop_ok) begin
            push(EV_BYTE, b, 1'b0);
            if (exp_match) begin
                exp_led = ~exp_led;
                push(EV_MATCH, 8'h00, exp_led);
            end
        end else begin
            push(EV_FERR, 8'h00, 1'b0);
        end
        @(negedge clk);
        rx = 1'b0;
        t_start = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (!stop_ok) repeat (CPB) @(negedge clk);
    endtask

    task automatic send_str(input string s, input bit match_at_end);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 1'b1, match_at_end && (i == s.len() - 1));
        end
    endtask

    task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", name, got, want);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        t_start  = 0;
        exp_led  = 1'b0;
        rx       = 1'b1;
        rst_n    = 1'b0;
        repeat (4) @(negedge clk);
        check_val("reset_rx_data",   rx_data,          8'h00);
        check_val("reset_rx_valid",  {7'd0, rx_valid}, 8'h00);
        check_val("reset_frame_err", {7'd0, frame_err},8'h00);
        check_val("reset_match",     {7'd0, match},    8'h00);
        check_val("reset_led",       {7'd0, led},      8'h00);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);

        // Clean bytes
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'hA3, 1'b1, 1'b0);

        // Pattern twice: led 0->1, then 1->0
        send_str("2000_10_29", 1'b1);
        send_str("2000_10_29", 1'b1);
        check_val("led_after_two", {7'd0, led}, 8'h00);

        // Fallback cases
        send_str("2000_10_2000_10_29", 1'b1);
        send_str("22000_10_29", 1'b1);
        send_str("2000_10_2X", 1'b0);
        check_val("led_after_fallback", {7'd0, led}, 8'h00);

        // Framing error in the middle of the pattern
        send_str("2000_", 1'b0);
        send_byte(8'h31, 1'b0, 1'b0);
        send_str("10_29", 1'b0);
        check_val("led_after_ferr", {7'd0, led}, 8'h00);

        // Glitch shorter than half a bit
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_byte(8'h41, 1'b1, 1'b0);

        // Reset in the data bits of a frame
        send_str("2000_1", 1'b0);
        check_val("queue_before_reset", 8'(exp_q.size()), 8'h00);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB * 3) @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check_val("midreset_rx_data",   rx_data,           8'h00);
        check_val("midreset_rx_valid",  {7'd0, rx_valid},  8'h00);
        check_val("midreset_frame_err", {7'd0, frame_err}, 8'h00);
        check_val("midreset_match",     {7'd0, match},     8'h00);
        check_val("midreset_led",       {7'd0, led},       8'h00);
        exp_led = 1'b0;
        rx = 1'b1;
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_str("2000_10_29", 1'b1);

        repeat (2 * CPB) @(negedge clk);
        check_val("queue_empty_end", 8'(exp_q.size()), 8'h00);
        check_val("led_end", {7'd0, led}, {7'd0, exp_led});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
